// File: rtl/kseg_invsqr_pkg.sv
// Shared fp16 constants, LUT entry format and the default mantissa-segment table.
// Latency n/a; backpressure n/a.
package kseg_invsqr_pkg;

    localparam logic [15:0] POS_INF = 16'h7C00;
    localparam logic [15:0] QNAN    = 16'h7E00;
    localparam int          BIAS    = 15;
    localparam int          OUT_OFS = 3 * BIAS;

    typedef struct packed {
        logic [1:0] adj;
        logic [9:0] frac;
    } lut_entry_t;

    typedef enum logic [1:0] {
        CL_NORM,
        CL_SUB,
        CL_INF,
        CL_NAN
    } cls_e;

    // Segment i covers mantissas around M/2^S; the entry holds 1/mid^2 renormalised to [1,2).
    function automatic lut_entry_t default_lut_entry(input int seg_bits, input int i);
        longint     one, s, li, m, msq, adj, q;
        lut_entry_t ent;
        one = 1;
        s   = seg_bits + 1;
        li  = i;
        m   = (one << s) + 2 * li + 1;
        msq = m * m;
        adj = ((one << (2 * s + 1)) < msq) ? 2 : 1;
        q   = (one << (2 * s + adj + 10)) / msq - 1024;
        ent.adj  = adj[1:0];
        ent.frac = q[9:0];
        return ent;
    endfunction

endpackage

// File: rtl/kseg_invsqr_lane.sv
// Per-lane combinational pieces: operand classification (S1) and saturate/pack (S3).
// Zero latency; no backpressure of its own, the top gates its registers.
module kseg_invsqr_lane
    import kseg_invsqr_pkg::*;
#(
    parameter int SEG_BITS = 2
) (
    input  logic [15:0]         op_i,
    output cls_e                cls_o,
    output logic [4:0]          exp_o,
    output logic [SEG_BITS-1:0] seg_o,
    input  cls_e                cls_i,
    input  logic signed [6:0]   e_i,
    input  logic [9:0]          frac_i,
    output logic [15:0]         res_o,
    output logic [1:0]          flags_o
);

    // The square is sign-independent.
    logic unused_sign;
    assign unused_sign = op_i[15];

    always_comb begin
        exp_o = op_i[14:10];
        seg_o = op_i[9 -: SEG_BITS];
        cls_o = CL_NORM;
        if (op_i[14:10] == 5'd0) begin
            cls_o = CL_SUB;
        end else if (op_i[14:10] == 5'd31) begin
            cls_o = (op_i[9:0] == 10'd0) ? CL_INF : CL_NAN;
        end
    end

    always_comb begin
        res_o   = '0;
        flags_o = '0;
        case (cls_i)
            CL_SUB: begin
                res_o   = POS_INF;
                flags_o = 2'b10;
            end
            CL_INF: begin
                flags_o = 2'b01;
            end
            CL_NAN: begin
                res_o = QNAN;
            end
            default: begin
                if (e_i >= 7'sd31) begin
                    res_o   = POS_INF;
                    flags_o = 2'b10;
                end else if (e_i <= 7'sd0) begin
                    flags_o = 2'b01;
                end else begin
                    res_o = {1'b0, e_i[4:0], frac_i};
                end
            end
        endcase
    end

endmodule

// File: rtl/kseg_invsqr_pipe.sv
// Pipelined approximate 1/x^2 on LANES fp16 operands with a shared programmable segment LUT.
// Latency 3 cycles; whole pipe stalls when the output is valid and not accepted.
module kseg_invsqr_pipe
    import kseg_invsqr_pkg::*;
#(
    parameter int LANES    = 4,
    parameter int SEG_BITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*16-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*16-1:0]   out_data,
    output logic [LANES*2-1:0]    out_flags,
    input  logic                  cfg_we,
    input  logic [SEG_BITS-1:0]   cfg_addr,
    input  logic [11:0]           cfg_data
);

    localparam int NSEG = 1 << SEG_BITS;

    lut_entry_t          lut_q     [NSEG];

    logic                s1_vld_q, s2_vld_q, out_vld_q;
    logic                advance;

    cls_e                s1_cls_d  [LANES];
    cls_e                s1_cls_q  [LANES];
    logic [4:0]          s1_exp_d  [LANES];
    logic [4:0]          s1_exp_q  [LANES];
    logic [SEG_BITS-1:0] s1_seg_d  [LANES];
    logic [SEG_BITS-1:0] s1_seg_q  [LANES];

    cls_e                s2_cls_q  [LANES];
    logic signed [6:0]   s2_e_d    [LANES];
    logic signed [6:0]   s2_e_q    [LANES];
    logic [9:0]          s2_frac_d [LANES];
    logic [9:0]          s2_frac_q [LANES];

    logic [15:0]         res_d     [LANES];
    logic [15:0]         out_dat_q [LANES];
    logic [1:0]          flg_d     [LANES];
    logic [1:0]          out_flg_q [LANES];

    assign advance   = !out_vld_q || out_ready;
    assign in_ready  = advance;
    assign out_valid = out_vld_q;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        kseg_invsqr_lane #(
            .SEG_BITS (SEG_BITS)
        ) u_lane (
            .op_i    (in_data[16*k +: 16]),
            .cls_o   (s1_cls_d[k]),
            .exp_o   (s1_exp_d[k]),
            .seg_o   (s1_seg_d[k]),
            .cls_i   (s2_cls_q[k]),
            .e_i     (s2_e_q[k]),
            .frac_i  (s2_frac_q[k]),
            .res_o   (res_d[k]),
            .flags_o (flg_d[k])
        );
        assign out_data[16*k +: 16] = out_dat_q[k];
        assign out_flags[2*k +: 2]  = out_flg_q[k];
    end

    // e = OUT_OFS - 2E - adj, wrapping in 7 bits to give the signed biased exponent.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            s2_frac_d[k] = lut_q[s1_seg_q[k]].frac;
            s2_e_d[k]    = 7'(OUT_OFS) - {1'b0, s1_exp_q[k], 1'b0}
                           - {5'b0, lut_q[s1_seg_q[k]].adj};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            out_vld_q <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                s1_cls_q[k]  <= CL_NORM;
                s1_exp_q[k]  <= '0;
                s1_seg_q[k]  <= '0;
                s2_cls_q[k]  <= CL_NORM;
                s2_e_q[k]    <= '0;
                s2_frac_q[k] <= '0;
                out_dat_q[k] <= '0;
                out_flg_q[k] <= '0;
            end
        end else if (advance) begin
            s1_vld_q  <= in_valid;
            s2_vld_q  <= s1_vld_q;
            out_vld_q <= s2_vld_q;
            for (int k = 0; k < LANES; k++) begin
                s1_cls_q[k]  <= s1_cls_d[k];
                s1_exp_q[k]  <= s1_exp_d[k];
                s1_seg_q[k]  <= s1_seg_d[k];
                s2_cls_q[k]  <= s1_cls_q[k];
                s2_e_q[k]    <= s2_e_d[k];
                s2_frac_q[k] <= s2_frac_d[k];
                out_dat_q[k] <= res_d[k];
                out_flg_q[k] <= flg_d[k];
            end
        end
    end

    // A write lands at the edge, so an S2 read in the same cycle still sees the old entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NSEG; i++) begin
                lut_q[i] <= default_lut_entry(SEG_BITS, i);
            end
        end else if (cfg_we) begin
            lut_q[cfg_addr] <= cfg_data;
        end
    end

endmodule

// File: tb/tb_kseg_invsqr_pipe.sv
// Self-checking bench for kseg_invsqr_pipe: directed cases plus randomized streams vs a reference model.
// Latency 3 expected; exercises random and patterned output stalls.
module tb_kseg_invsqr_pipe;

    localparam int L  = 4;
    localparam int SB = 2;
    localparam int W  = L * 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [2*L-1:0]   out_flags;
    logic             cfg_we;
    logic [SB-1:0]    cfg_addr;
    logic [11:0]      cfg_data;

    int errors = 0;
    int checks = 0;

    logic [11:0]      mlut [4];
    logic [W-1:0]     in_q  [$];
    logic [W-1:0]     got_d [$];
    logic [2*L-1:0]   got_f [$];

    kseg_invsqr_pipe #(.LANES(L), .SEG_BITS(SB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_default_lut();
        mlut[0] = {2'd1, 10'd594};
        mlut[1] = {2'd1, 10'd59};
        mlut[2] = {2'd2, 10'd527};
        mlut[3] = {2'd2, 10'd141};
    endtask

    // Reference: y = 2^(e-15) * (1 + frac/1024), e = 45 - 2E - adj, with fp16 specials.
    function automatic logic [17:0] model_lane(input logic [15:0] x);
        int ex, m, seg, adj, frac, e;
        ex = int'(x[14:10]);
        m  = int'(x[9:0]);
        if (ex == 0) return {2'b10, 16'h7C00};
        if (ex == 31) return (m == 0) ? {2'b01, 16'h0000} : {2'b00, 16'h7E00};
        seg  = m / (1024 / (1 << SB));
        adj  = int'(mlut[seg][11:10]);
        frac = int'(mlut[seg][9:0]);
        e    = 45 - 2 * ex - adj;
        if (e >= 31) return {2'b10, 16'h7C00};
        if (e <= 0) return {2'b01, 16'h0000};
        return {2'b00, 1'b0, 5'(e), 10'(frac)};
    endfunction

    function automatic logic [W+2*L-1:0] model_beat(input logic [W-1:0] b);
        logic [W+2*L-1:0] r;
        logic [17:0]      t;
        r = '0;
        for (int k = 0; k < L; k++) begin
            t = model_lane(b[16*k +: 16]);
            r[16*k +: 16]  = t[15:0];
            r[W+2*k +: 2]  = t[17:16];
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_beat();
        logic [W-1:0] b;
        for (int k = 0; k < L; k++) b[16*k +: 16] = 16'($urandom);
        return b;
    endfunction

    // Assumes an idle pipe; returns the first output beat and cycles from acceptance.
    task automatic send_one(input logic [W-1:0] b, output logic [W-1:0] d,
                            output logic [2*L-1:0] f, output int lat);
        in_valid  = 1'b1;
        in_data   = b;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        lat = -1;
        d   = '0;
        f   = '0;
        for (int c = 1; c <= 20; c++) begin
            if (out_valid) begin
                lat = c;
                d   = out_data;
                f   = out_flags;
                break;
            end
            step();
        end
        step();
    endtask

    task automatic run_stream(input int stall_pct, input int gap_pct, output int timeout);
        int sent = 0;
        int n    = in_q.size();
        int cyc  = 0;
        got_d.delete();
        got_f.delete();
        while (got_d.size() < n && cyc < 2000) begin
            in_valid  = (sent < n) && ($urandom_range(99) >= gap_pct);
            in_data   = in_valid ? in_q[sent] : rand_beat();
            out_ready = ($urandom_range(99) >= stall_pct);
            #1;
            if (out_valid && out_ready) begin
                got_d.push_back(out_data);
                got_f.push_back(out_flags);
            end
            if (in_valid && in_ready) sent++;
            step();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        timeout   = (cyc >= 2000) ? 1 : 0;
    endtask

    task automatic check_stream(input string name, input int timeout);
        logic [W+2*L-1:0] exp;
        checks++;
        if (timeout != 0 || got_d.size() != in_q.size()) begin
            errors++;
            $display("FAIL %s count: got %0d beats, expected %0d (timeout=%0d)",
                     name, got_d.size(), in_q.size(), timeout);
        end
        for (int i = 0; i < got_d.size() && i < in_q.size(); i++) begin
            exp = model_beat(in_q[i]);
            checks++;
            if (got_d[i] !== exp[W-1:0] || got_f[i] !== exp[W +: 2*L]) begin
                errors++;
                $display("FAIL %s beat %0d: in=%h got data=%h flags=%b expected data=%h flags=%b",
                         name, i, in_q[i], got_d[i], got_f[i], exp[W-1:0], exp[W +: 2*L]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_flags !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b data=%h flags=%b expected 0/0/0",
                     out_valid, out_data, out_flags);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [W-1:0]   d;
        logic [2*L-1:0] f;
        int             lat;
        send_one({16'h3C00, 16'hC000, 16'h4000, 16'h3C00}, d, f, lat);
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL basic_latency: got %0d expected 3", lat);
        end
        checks++;
        if (d !== {16'h3A52, 16'h3252, 16'h3252, 16'h3A52} || f !== 8'h00) begin
            errors++;
            $display("FAIL basic_value: got %h/%b expected 3a52325232523a52/00000000", d, f);
        end
    endtask

    task automatic test_specials();
        logic [W-1:0]   d;
        logic [2*L-1:0] f;
        int             lat;
        send_one({16'h7E01, 16'h7C00, 16'h03FF, 16'h0000}, d, f, lat);
        checks++;
        if (lat != 3 || d !== {16'h7E00, 16'h0000, 16'h7C00, 16'h7C00} || f !== 8'b00_01_10_10) begin
            errors++;
            $display("FAIL specials: lat=%0d got %h/%b expected 7e0000007c007c00/00011010", lat, d, f);
        end
    endtask

    task automatic test_saturation();
        logic [W-1:0]   d;
        logic [2*L-1:0] f;
        int             lat;
        send_one({16'h3C00, 16'h5400, 16'h5800, 16'h1800}, d, f, lat);
        checks++;
        if (lat != 3 || d !== {16'h3A52, 16'h0A52, 16'h0000, 16'h7C00} || f !== 8'b00_00_01_10) begin
            errors++;
            $display("FAIL saturation: lat=%0d got %h/%b expected 3a520a5200007c00/00000110", lat, d, f);
        end
    endtask

    task automatic test_random(input string name, input int n, input int stall_pct, input int gap_pct);
        int to;
        in_q.delete();
        for (int i = 0; i < n; i++) in_q.push_back(rand_beat());
        run_stream(stall_pct, gap_pct, to);
        check_stream(name, to);
    endtask

    task automatic test_back_pressure();
        int             sent = 0;
        logic           prev_stall = 1'b0;
        logic [W-1:0]   held_d = '0;
        logic [2*L-1:0] held_f = '0;
        in_q.delete();
        got_d.delete();
        got_f.delete();
        for (int i = 0; i < 8; i++) in_q.push_back(rand_beat());
        for (int c = 0; c < 200 && got_d.size() < 8; c++) begin
            in_valid  = (sent < 8);
            in_data   = in_valid ? in_q[sent] : '0;
            out_ready = (c % 4 == 0) || (c % 4 == 3);
            #1;
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== held_d || out_flags !== held_f) begin
                    errors++;
                    $display("FAIL bp_hold: cycle %0d got %b/%h/%b expected 1/%h/%b",
                             c, out_valid, out_data, out_flags, held_d, held_f);
                end
            end
            if (out_valid && !out_ready) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_in_ready: cycle %0d got %b expected 0", c, in_ready);
                end
                prev_stall = 1'b1;
                held_d     = out_data;
                held_f     = out_flags;
            end else begin
                prev_stall = 1'b0;
            end
            if (out_valid && out_ready) begin
                got_d.push_back(out_data);
                got_f.push_back(out_flags);
            end
            if (in_valid && in_ready) sent++;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_stream("bp_stream", 0);
    endtask

    task automatic test_lut_coincident();
        int lat = -1;
        in_valid  = 1'b1;
        in_data   = {4{16'h3C00}};
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        cfg_we   = 1'b1;
        cfg_addr = 2'd0;
        cfg_data = {2'd2, 10'd100};
        step();
        cfg_we = 1'b0;
        for (int c = 2; c <= 20; c++) begin
            if (out_valid) begin
                lat = c;
                break;
            end
            step();
        end
        checks++;
        if (lat != 3 || out_data !== {4{16'h3A52}}) begin
            errors++;
            $display("FAIL lut_coincident: lat=%0d got %h expected 3a52 in every lane", lat, out_data);
        end
        step();
        mlut[0] = {2'd2, 10'd100};
    endtask

    task automatic test_lut_write();
        logic [W-1:0]   d;
        logic [2*L-1:0] f;
        int             lat;
        cfg_we   = 1'b1;
        cfg_addr = 2'd0;
        cfg_data = {2'd1, 10'd0};
        step();
        cfg_we  = 1'b0;
        mlut[0] = {2'd1, 10'd0};
        send_one({4{16'h3C00}}, d, f, lat);
        checks++;
        if (lat != 3 || d !== {4{16'h3800}} || f !== 8'h00) begin
            errors++;
            $display("FAIL lut_write: lat=%0d got %h/%b expected 3800 in every lane, flags 0", lat, d, f);
        end
    endtask

    task automatic test_reset_midstream();
        logic [W-1:0]   d;
        logic [2*L-1:0] f;
        int             lat;
        int             stale = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = rand_beat();
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_flags !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: valid=%b data=%h flags=%b expected 0/0/0",
                     out_valid, out_data, out_flags);
        end
        rst_n     = 1'b1;
        out_ready = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_in_ready: got %b expected 1", in_ready);
        end
        for (int c = 0; c < 6; c++) begin
            if (out_valid) stale++;
            step();
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL midreset_stale: got %0d stale beats expected 0", stale);
        end
        set_default_lut();
        send_one({4{16'h3C00}}, d, f, lat);
        checks++;
        if (lat != 3 || d !== {4{16'h3A52}} || f !== 8'h00) begin
            errors++;
            $display("FAIL midreset_lut_restore: lat=%0d got %h/%b expected 3a52 in every lane", lat, d, f);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        set_default_lut();

        test_reset();
        test_basic();
        test_specials();
        test_saturation();
        test_random("rand_default", 40, 30, 30);
        test_back_pressure();
        test_lut_coincident();
        test_lut_write();
        test_random("rand_reprogrammed", 30, 50, 20);
        test_reset_midstream();
        test_random("rand_after_reset", 20, 20, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
